// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes arrive on the rising edge of start_UART and are queued in a small
// FIFO. Each byte is sent on tx as a start bit, eight data bits (LSB first)
// and a stop bit, with CLKS_PER_BIT clocks per bit. When the stop bit of one
// frame ends and another byte is waiting, the next start bit begins at once.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_UART    send strobe (level); each rising edge requests one push
//   data_in_UART  byte to queue, sampled on the cycle the edge is seen
//   tx            serial output, idles high (registered)
//   busy          FIFO non-empty or a frame in progress
//   fifo_full     FIFO holds FIFO_DEPTH entries
//   overflow      sticky: a request was dropped because the FIFO was full
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_UART,
  input  logic [7:0] data_in_UART,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic              start_q;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  logic push_req;
  logic push_ok;
  logic baud_done;
  logic pop;

  assign push_req  = start_UART && !start_q;
  // Fullness is judged on the count before any same-cycle pop, so a request
  // landing on the pop edge of a full FIFO is still dropped.
  assign push_ok   = push_req && (count != DEPTH_C);
  assign baud_done = (baud_cnt == BAUD_LAST);
  // A byte leaves the FIFO when a start bit is launched: from IDLE, or
  // straight out of the final stop-bit cycle for gapless frames.
  assign pop       = (count != '0) &&
                     ((state == IDLE) || ((state == STOP) && baud_done));

  assign busy      = (state != IDLE) || (count != '0);
  assign fifo_full = (count == DEPTH_C);

  // Control: edge detect, FIFO bookkeeping, frame FSM and serial output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else begin
      start_q <= start_UART;

      if (push_ok)                 wr_ptr   <= wr_ptr + 1'b1;
      if (push_req && !push_ok)    overflow <= 1'b1;
      if (pop)                     rd_ptr   <= rd_ptr + 1'b1;

      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // shift is moving right this same edge, so shift[1] is the
              // next bit to present.
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

  // Data: FIFO storage and transmit shift register
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in_UART;
    if (pop)
      shift <= mem[rd_ptr];
    else if ((state == DATA) && baud_done)
      shift <= {1'b0, shift[7:1]};
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A serial monitor decodes every frame on tx and compares it against a queue
// of expected bytes filled as stimulus is driven.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_UART = 1'b0;
  logic [7:0] data_in_UART = 8'h00;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_UART   (start_UART),
    .data_in_UART (data_in_UART),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  int         mon_starts[$];
  int         frames_done = 0;

  typedef struct {
    logic [7:0] data;
    int         hold;
    logic [9:0] frame;   // bit i = i-th serial bit (start first, stop last)
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Serial monitor, sampling on the falling edge
  initial begin
    int         cnt;
    bit         active;
    bit         glitch;
    logic [9:0] bits;
    logic [7:0] exp;
    active = 0;
    cnt    = 0;
    glitch = 0;
    bits   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
      end else begin
        if (!active && tx === 1'b0) begin
          active = 1;
          cnt    = 0;
          glitch = 0;
          mon_starts.push_back(cyc);
        end
        if (active) begin
          if (cnt % CPB == 0) bits[cnt / CPB] = tx;
          else if (tx !== bits[cnt / CPB]) glitch = 1;
          cnt++;
          if (cnt == FRAME) begin
            active = 0;
            check("framing", {29'd0, bits[9], bits[0], glitch}, 32'b100);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 32'd1, 32'd0);
            end else begin
              exp = exp_q.pop_front();
              check("frame_byte", {24'd0, bits[8:1]}, {24'd0, exp});
            end
            frames_done++;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accept);
    start_UART   = 1'b1;
    data_in_UART = d;
    tick();
    start_UART = 1'b0;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i = 0;
    while (frames_done < n && i < budget) begin
      tick();
      i++;
    end
    check("frames_done", frames_done, n);
  endtask

  task automatic pop_edge_test(input int off);
    int p;
    int f;
    int base;
    apply_reset();
    base = frames_done;
    push_byte(8'h21, 1'b1);
    p = cyc;
    f = p + 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      push_byte(8'h22 + 8'(i), 1'b1);
      tick();
    end
    check("pe_full", {31'd0, fifo_full}, 32'd1);
    while (cyc < f + 39 + off) tick();
    check("pe_ovf_before", {31'd0, overflow}, 32'd0);
    push_byte(8'h26, off != 0);
    if (off == 0) begin
      check("pe_drop_ovf", {31'd0, overflow}, 32'd1);
      check("pe_drop_full", {31'd0, fifo_full}, 32'd0);
    end else begin
      check("pe_acc_ovf", {31'd0, overflow}, 32'd0);
      check("pe_acc_full", {31'd0, fifo_full}, 32'd1);
    end
    wait_frames(base + 5 + off, 8 * FRAME);
    repeat (3) tick();
    check("pe_busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   p;
    int   f;
    int   b;
    int   lows;
    vec_t v;

    vecs[0] = '{8'hA5, 1,  10'b1101001010};
    vecs[1] = '{8'h3C, 20, 10'b1001111000};
    vecs[2] = '{8'h00, 1,  10'b1000000000};
    vecs[3] = '{8'hFF, 3,  10'b1111111110};
    vecs[4] = '{8'h81, 1,  10'b1100000010};

    apply_reset();
    repeat (3) tick();
    check("idle_tx", {31'd0, tx}, 32'd1);

    // Single frames from the vector table, bit-by-bit timing
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      start_UART   = 1'b1;
      data_in_UART = v.data;
      tick();
      exp_q.push_back(v.data);
      check("tx_before_fall", {31'd0, tx}, 32'd1);
      check("busy_rise", {31'd0, busy}, 32'd1);
      if (v.hold == 1) start_UART = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        tick();
        check("tx_bit", {31'd0, tx}, {31'd0, v.frame[k / CPB]});
        if (k > 0 && k < FRAME - 1)
          check("busy_mid", {31'd0, busy}, 32'd1);
        if (k + 2 == v.hold) start_UART = 1'b0;
      end
      tick();
      check("busy_fall", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 6; k++) begin
        check("tx_idle_after", {31'd0, tx}, 32'd1);
        tick();
      end
    end
    check("vec_frames", frames_done, 5);

    // Back-to-back frames on alternate-cycle pushes
    b = mon_starts.size();
    push_byte(8'h01, 1'b1);
    tick();
    push_byte(8'h02, 1'b1);
    tick();
    push_byte(8'h03, 1'b1);
    wait_frames(8, 4 * FRAME);
    check("b2b_gap1", mon_starts[b + 1] - mon_starts[b], FRAME);
    check("b2b_gap2", mon_starts[b + 2] - mon_starts[b + 1], FRAME);

    // Overflow while frame 1 is in flight
    repeat (4) tick();
    push_byte(8'h55, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ov_full_pre", {31'd0, fifo_full}, 32'd0);
      push_byte(8'h10 + 8'(i), 1'b1);
      tick();
    end
    check("ov_full", {31'd0, fifo_full}, 32'd1);
    check("ov_before", {31'd0, overflow}, 32'd0);
    push_byte(8'h14, 1'b0);
    check("ov_set", {31'd0, overflow}, 32'd1);
    wait_frames(13, 7 * FRAME);
    repeat (3) tick();
    check("ov_sticky", {31'd0, overflow}, 32'd1);
    check("ov_full_end", {31'd0, fifo_full}, 32'd0);

    // Request on the pop edge of a full FIFO, then one cycle later
    pop_edge_test(0);
    pop_edge_test(1);

    // Reset during DATA bit 3 with two bytes queued
    apply_reset();
    b = frames_done;
    push_byte(8'hFF, 1'b1);
    p = cyc;
    f = p + 1;
    tick();
    push_byte(8'h77, 1'b1);
    tick();
    push_byte(8'h88, 1'b1);
    while (cyc < f + 17) tick();
    check("mr_busy_before", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mr_tx", {31'd0, tx}, 32'd1);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_full", {31'd0, fifo_full}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("mr_quiet", lows, 0);
    check("mr_no_frame", frames_done, b);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter: the serial-out end of the memory-mapped UART channel. It accepts bytes from the data memory's UART-send strobe (`start_UART` / `data_in_UART`, raised while a byte store targets address 0x400). It queues them in a small FIFO and shifts each out on `tx`, LSB first, at a fixed baud rate. The block absorbs back-to-back stores from the processor without stalling the pipeline and reports occupancy and overflow status.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per serial bit. Must be ≥ 2; 868 corresponds to 115200 baud at 100 MHz.
- FIFO_DEPTH, default 4: number of byte entries. Must be a power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start_UART  input  1  send strobe from memory; level signal, a rising edge requests one byte
- data_in_UART  input  8  byte to send; sampled on the cycle the rising edge is detected
- tx  output  1  serial line; idles high
- busy  output  1  high while the FIFO is non-empty or a frame is in progress
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries
- overflow  output  1  sticky flag: a request was dropped because the FIFO was full

## Operation
- Edge detect:
  - Register start_q <= start_UART.
  - A push request occurs when start_UART && !start_q.
  - A strobe held high for many cycles yields exactly one push.
  - start_q resets to 0, so a strobe already high at the first edge after reset is one push.
- Push:
  - If a request occurs and count < FIFO_DEPTH (count evaluated before any same-cycle pop), write data_in_UART at wr_ptr, then increment wr_ptr and count.
  - If count == FIFO_DEPTH, drop the byte and set overflow. This applies even if a pop happens in the same cycle.
- Pointers: wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count > 0, pop the entry at rd_ptr into shift register, go to START, drive tx=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit_idx==7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if count > 0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits. Cleared on every state or bit change; the terminal value is CLKS_PER_BIT-1.
- Outputs:
  - tx is a register.
  - busy = (state != IDLE) || (count != 0).
  - fifo_full = (count == FIFO_DEPTH).
  - overflow is cleared only by reset.

## Timing
- Reset values: tx=1, busy=0, fifo_full=0, overflow=0. FSM=IDLE, pointers, count and start_q = 0.
- Reset mid-frame: tx returns to 1 asynchronously, the FIFO is emptied, and the partial frame is discarded.
- Latency: a push at edge P makes the FIFO non-empty after P. With the FSM in IDLE, tx falls at edge P+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles from tx falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- busy rises the cycle after the push edge and falls on the edge that ends the last stop bit with the FIFO empty.
- Pop timing: the FIFO slot is freed at the IDLE→START or STOP→START edge, not at frame end. A full FIFO therefore accepts a new push one cycle after a pop.

## Test plan
Scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Single byte: strobe one cycle with 0xA5 → tx falls 1 cycle after the push edge, then 0,1,0,1,0,0,1,0,1,1 at 4 cycles each; busy drops after 40 cycles; idle line stays high.
- Held strobe: start_UART high for 20 cycles with 0x3C → exactly one frame (40 cycles) is sent and count never exceeds 1.
- Back-to-back: push 0x01, 0x02, 0x03 on alternate cycles → three frames are sent with no gap (120 contiguous cycles), bytes in order.
- Overflow:
  - While frame 1 is sending, push 5 more bytes 0x10–0x14 → the first 4 queue, fifo_full=1, and the 5th (0x14) is dropped with overflow=1.
  - Output order is the frame-1 byte, then 0x10–0x13; overflow stays 1 afterward.
- Push-on-pop edge: with the FIFO full, raise the strobe on the cycle of the STOP→START pop → the byte is dropped and overflow sets. Raised one cycle later, the byte is accepted.
- Reset mid-frame: assert rst_n low during DATA bit 3 of 0xFF with 2 bytes queued → tx=1 immediately, busy=0, fifo_full=0. After release with no strobe, tx stays high with no frame.
